// File: rtl/mult_booth4.sv
// mult_booth4 -- sequential signed 32x32 multiplier, radix-4 (modified) Booth.
//
// Latches the operands on a one-cycle ctrl_MULT pulse, retires two multiplier
// bits per clock over 16 iterations and returns the low 32 bits of the signed
// 64-bit product together with an overflow flag and a one-cycle ready pulse.
//
// Ports:
//   clk             rising-edge clock
//   reset           synchronous, active-high; clears state and outputs
//   ctrl_MULT       start pulse; restarts the unit if an operation is running
//   data_operandA   multiplicand M (two's complement), sampled on ctrl_MULT
//   data_operandB   multiplier Q (two's complement), sampled on ctrl_MULT
//   data_result     product bits [31:0], held until the next completion
//   data_exception  product does not fit in a signed 32-bit value
//   data_resultRDY  one-cycle pulse while result/exception are fresh
//   busy            high while an operation is in progress (RUN or DONE)
module mult_booth4 (
    input  logic        clk,
    input  logic        reset,
    input  logic        ctrl_MULT,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state;
    state_t             state_nxt;

    logic signed [31:0] m_p0;       // latched multiplicand
    logic signed [33:0] acc_p0;     // upper partial product, two guard bits
    logic        [31:0] mq_p0;      // shifting multiplier / low product
    logic               guard_p0;   // bit shifted out of mq (Booth q[-1])
    logic        [3:0]  count_p0;

    logic signed [33:0] sum;
    logic signed [33:0] acc_nxt;
    logic        [31:0] mq_nxt;
    logic               finish;

    // Booth partial product for one radix-4 digit; 34 bits so that +/-2M
    // of the most negative multiplicand is representable.
    function automatic logic signed [33:0] booth_pp(input logic [2:0] trip,
                                                    input logic signed [31:0] m);
        logic signed [33:0] m34;
        m34 = {{2{m[31]}}, m};
        case (trip)
            3'b001, 3'b010: return m34;
            3'b011:         return m34 <<< 1;
            3'b100:         return -(m34 <<< 1);
            3'b101, 3'b110: return -m34;
            default:        return '0;
        endcase
    endfunction

    // The product fits in 32 signed bits only if every upper bit equals the
    // sign of the low word.
    function automatic logic ovf_check(input logic [33:0] acc, input logic sign);
        return acc != {34{sign}};
    endfunction

    // Iteration datapath: add the recoded digit, then arithmetic shift right
    // by two across {acc, mq, guard}.
    always_comb begin
        sum     = acc_p0 + booth_pp({mq_p0[1:0], guard_p0}, m_p0);
        acc_nxt = {{2{sum[33]}}, sum[33:2]};
        mq_nxt  = {sum[1:0], mq_p0[31:2]};
    end

    // A start pulse always wins, so a start on the final iteration edge
    // suppresses completion of the aborted operation.
    assign finish = (state == RUN) && !ctrl_MULT && (count_p0 == 4'd15);

    always_comb begin
        state_nxt = state;
        if (ctrl_MULT) begin
            state_nxt = RUN;
        end else begin
            case (state)
                IDLE:    state_nxt = IDLE;
                RUN:     state_nxt = finish ? DONE : RUN;
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);

    // Multiplicand capture (pure data, no clear needed)
    always_ff @(posedge clk) begin
        if (ctrl_MULT) begin
            m_p0 <= data_operandA;
        end
    end

    // Control, iteration state and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            acc_p0         <= '0;
            mq_p0          <= '0;
            guard_p0       <= 1'b0;
            count_p0       <= '0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else begin
            state          <= state_nxt;
            data_resultRDY <= finish;
            if (ctrl_MULT) begin
                acc_p0   <= '0;
                mq_p0    <= data_operandB;
                guard_p0 <= 1'b0;
                count_p0 <= '0;
            end else if (state == RUN) begin
                acc_p0   <= acc_nxt;
                mq_p0    <= mq_nxt;
                guard_p0 <= mq_p0[1];
                count_p0 <= count_p0 + 4'd1;
                if (finish) begin
                    data_result    <= mq_nxt;
                    data_exception <= ovf_check(acc_nxt, mq_nxt[31]);
                end
            end
        end
    end

endmodule

// File: tb/tb_mult_booth4.sv
// tb_mult_booth4 -- directed self-checking bench for mult_booth4.
module tb_mult_booth4;

    logic        clk = 1'b0;
    logic        reset;
    logic        ctrl_MULT;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int checks = 0;
    int errors = 0;

    mult_booth4 dut (
        .clk            (clk),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Pulse ctrl_MULT for one edge (E0); returns #1 after E0 with the
    // operand inputs scrambled so later changes must be ignored.
    task automatic start_pulse(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT     = 1'b1;
        @(posedge clk);
        #1;
        ctrl_MULT     = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    // Wait (bounded) for resultRDY; lat counts edges after E0, -1 on timeout.
    task automatic wait_rdy(output int lat, output bit held, output bit busy_ok);
        logic [31:0] r0;
        r0      = data_result;
        held    = 1'b1;
        busy_ok = 1'b1;
        lat     = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (data_resultRDY === 1'b1) begin
                lat = n;
                break;
            end
            if (data_result !== r0) held = 1'b0;
        end
    endtask

    task automatic run_vec(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_res, input logic exp_exc, input bit tail);
        int lat;
        bit held;
        bit busy_ok;
        start_pulse(a, b);
        chk({tag, "_busy_e0"}, busy, 1);
        chk({tag, "_rdy_e0"}, data_resultRDY, 0);
        wait_rdy(lat, held, busy_ok);
        chk({tag, "_latency"}, lat, 16);
        chk({tag, "_held"}, held, 1);
        chk({tag, "_busy_run"}, busy_ok, 1);
        chk({tag, "_result"}, data_result, exp_res);
        chk({tag, "_exception"}, data_exception, exp_exc);
        if (tail) begin
            @(posedge clk);
            #1;
            chk({tag, "_rdy_pulse_end"}, data_resultRDY, 0);
            chk({tag, "_busy_end"}, busy, 0);
            chk({tag, "_result_hold"}, data_result, exp_res);
        end
    endtask

    initial begin
        int          lat;
        bit          held;
        bit          busy_ok;
        int          rdy_seen;
        int          busy_seen;
        logic [31:0] prev;
        logic [31:0] ra;
        logic [31:0] rb;
        longint      pa;
        longint      pb;
        longint      prod;
        logic [63:0] pv;

        reset         = 1'b1;
        ctrl_MULT     = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_result", data_result, 0);
        chk("reset_exception", data_exception, 0);
        chk("reset_rdy", data_resultRDY, 0);
        chk("reset_busy", busy, 0);
        @(negedge clk);
        reset = 1'b0;

        run_vec("3x4",      32'd3,          32'd4,          32'd12,         1'b0, 1);
        run_vec("m7x6",     32'hFFFFFFF9,   32'd6,          32'hFFFFFFD6,   1'b0, 1);
        run_vec("min_x1",   32'h80000000,   32'd1,          32'h80000000,   1'b0, 1);
        run_vec("max_x2",   32'h7FFFFFFF,   32'd2,          32'hFFFFFFFE,   1'b1, 1);
        run_vec("min_xm1",  32'h80000000,   32'hFFFFFFFF,   32'h80000000,   1'b1, 1);
        run_vec("2p16sq",   32'd65536,      32'd65536,      32'd0,          1'b1, 1);
        run_vec("min_sq",   32'h80000000,   32'h80000000,   32'd0,          1'b1, 1);
        run_vec("m1xm1",    32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          1'b0, 1);
        run_vec("mixed",    32'd12345,      32'hFFFFE57B,   32'hFB012863,   1'b0, 1);

        // Abort: restart with 9x9 partway through 5x5
        prev = data_result;
        start_pulse(32'd5, 32'd5);
        rdy_seen = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (data_resultRDY === 1'b1) rdy_seen++;
        end
        chk("abort_no_rdy_first", rdy_seen, 0);
        start_pulse(32'd9, 32'd9);
        chk("abort_prev_held", data_result, prev);
        wait_rdy(lat, held, busy_ok);
        chk("abort_latency", lat, 16);
        chk("abort_held", held, 1);
        chk("abort_result", data_result, 32'd81);
        chk("abort_exception", data_exception, 0);
        @(posedge clk);
        #1;
        chk("abort_single_rdy", data_resultRDY, 0);

        // Reset mid-run
        start_pulse(32'd5, 32'd5);
        repeat (9) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_result", data_result, 0);
        chk("midrst_exception", data_exception, 0);
        chk("midrst_rdy", data_resultRDY, 0);
        chk("midrst_busy", busy, 0);
        @(negedge clk);
        reset = 1'b0;
        rdy_seen = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (data_resultRDY === 1'b1) rdy_seen++;
        end
        chk("midrst_no_rdy", rdy_seen, 0);
        run_vec("post_rst_2x3", 32'd2, 32'd3, 32'd6, 1'b0, 1);

        // Reset and start on the same edge: reset wins
        @(negedge clk);
        reset         = 1'b1;
        ctrl_MULT     = 1'b1;
        data_operandA = 32'd7;
        data_operandB = 32'd7;
        @(posedge clk);
        #1;
        reset     = 1'b0;
        ctrl_MULT = 1'b0;
        chk("rst_start_busy", busy, 0);
        chk("rst_start_result", data_result, 0);
        rdy_seen  = 0;
        busy_seen = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (data_resultRDY === 1'b1) rdy_seen++;
            if (busy === 1'b1) busy_seen++;
        end
        chk("rst_start_no_rdy", rdy_seen, 0);
        chk("rst_start_idle", busy_seen, 0);

        // Random signed operands, back-to-back starts at E17
        for (int i = 0; i < 8; i++) begin
            ra   = $urandom;
            rb   = $urandom;
            if (i == 0) rb = 32'hFFFFFFFF;
            pa   = longint'($signed(ra));
            pb   = longint'($signed(rb));
            prod = pa * pb;
            pv   = prod;
            run_vec($sformatf("rand%0d", i), ra, rb, pv[31:0],
                    (pv[63:31] != {33{pv[31]}}), (i == 7));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
